// File: rtl/io_channel_file_if.sv
// CPU register port plus per-channel ready/valid streams of io_channel_file.
// Build with IO_PARITY_EN to widen each input word by one odd-parity bit.
interface io_channel_file_if #(
  parameter int WIDTH   = 15,
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 4
);
`ifdef IO_PARITY_EN
  localparam int IW = WIDTH + 1;
`else
  localparam int IW = WIDTH;
`endif

  logic [4:0]             sel_read;
  logic [WIDTH-1:0]       data_read;
  logic [4:0]             sel_write;
  logic                   en_write;
  logic [WIDTH-1:0]       data_write;
  logic [NUM_IN*IW-1:0]   in_data;
  logic [NUM_IN-1:0]      in_valid;
  logic [NUM_IN-1:0]      in_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]     out_valid;
  logic [NUM_OUT-1:0]     out_ready;

  modport slave (
    input  sel_read, sel_write, en_write, data_write, in_data, in_valid, out_ready,
    output data_read, in_ready, out_data, out_valid
  );

  modport master (
    output sel_read, sel_write, en_write, data_write, in_data, in_valid, out_ready,
    input  data_read, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/io_channel_file.sv
// Register file bridging serial receivers/transmitters to a CPU read/write port.
// Optional feature macro IO_PARITY_EN: odd-parity check on inputs plus error counter at sel 29.
module io_channel_file #(
  parameter int WIDTH   = 15,
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 4
) (
  input logic           clock,
  input logic           reset,
  io_channel_file_if.slave bus
);
`ifdef IO_PARITY_EN
  localparam int IW = WIDTH + 1;
`else
  localparam int IW = WIDTH;
`endif

  logic [NUM_IN-1:0]  fresh;
  logic [WIDTH-1:0]   in_word [NUM_IN];
  logic [NUM_IN-1:0]  take;
  logic [NUM_IN-1:0]  keep;
  logic [WIDTH-1:0]   out_word [NUM_OUT];
  logic [NUM_OUT-1:0] out_vld;
  logic [WIDTH-1:0]   rd_mux_p0;

`ifdef IO_PARITY_EN
  logic [7:0] err_cnt;
  logic [4:0] n_bad;

  function automatic logic parity_ok(input logic [IW-1:0] w);
    return ^w;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
`endif

  assign bus.in_ready  = ~fresh;
  assign bus.out_valid = out_vld;

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign bus.out_data[j*WIDTH +: WIDTH] = out_word[j];
  end

  // A handshake completes whenever the slot is empty; bad-parity words are then dropped.
  always_comb begin
    take = '0;
    keep = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      take[i] = bus.in_valid[i] & ~fresh[i];
`ifdef IO_PARITY_EN
      keep[i] = take[i] & parity_ok(bus.in_data[i*IW +: IW]);
`else
      keep[i] = take[i];
`endif
    end
  end

`ifdef IO_PARITY_EN
  always_comb begin
    n_bad = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (take[i] && !keep[i]) n_bad = n_bad + 5'd1;
  end
`endif

  always_comb begin
    rd_mux_p0 = '0;
    if (bus.sel_read == 5'd30)
      rd_mux_p0[NUM_IN-1:0] = fresh;
    else if (bus.sel_read == 5'd31)
      rd_mux_p0[NUM_OUT-1:0] = out_vld;
`ifdef IO_PARITY_EN
    else if (bus.sel_read == 5'd29)
      rd_mux_p0 = WIDTH'(err_cnt);
`endif
    else begin
      for (int i = 0; i < NUM_IN; i++)
        if (bus.sel_read == 5'(i)) rd_mux_p0 = in_word[i];
    end
  end

  // p0 -> p1: read data registered; channel state updated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fresh         <= '0;
      out_vld       <= '0;
      bus.data_read <= '0;
      for (int i = 0; i < NUM_IN; i++)  in_word[i]  <= '0;
      for (int j = 0; j < NUM_OUT; j++) out_word[j] <= '0;
`ifdef IO_PARITY_EN
      err_cnt       <= '0;
`endif
    end else begin
      bus.data_read <= rd_mux_p0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (keep[i]) begin
          in_word[i] <= bus.in_data[i*IW +: WIDTH];
          fresh[i]   <= 1'b1;
        end else if (bus.sel_read == 5'(i)) begin
          fresh[i]   <= 1'b0;
        end
      end
      // A CPU write wins over a completing handshake so the new word is never lost.
      for (int j = 0; j < NUM_OUT; j++) begin
        if (bus.en_write && bus.sel_write == 5'(j)) begin
          out_word[j] <= bus.data_write;
          out_vld[j]  <= 1'b1;
        end else if (bus.out_ready[j]) begin
          out_vld[j]  <= 1'b0;
        end
      end
`ifdef IO_PARITY_EN
      err_cnt <= sat_add(err_cnt, n_bad);
`endif
    end
  end
endmodule

// File: tb/tb_io_channel_file.sv
// Directed and randomized bench for io_channel_file against a transaction-level model.
module tb_io_channel_file;
  localparam int WIDTH   = 15;
  localparam int NUM_IN  = 6;
  localparam int NUM_OUT = 4;
`ifdef IO_PARITY_EN
  localparam int IW = WIDTH + 1;
`else
  localparam int IW = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  io_channel_file_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

  io_channel_file #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Model: each input slot is "empty" or "holds an unread word"; outputs are pending or idle.
  logic [WIDTH-1:0]   m_word [NUM_IN];
  bit                 m_fresh [NUM_IN];
  logic [WIDTH-1:0]   m_out [NUM_OUT];
  bit                 m_pend [NUM_OUT];
  logic [WIDTH-1:0]   m_rd;
  int                 m_err;

  function automatic void model_reset();
    for (int i = 0; i < NUM_IN; i++) begin m_word[i] = '0; m_fresh[i] = 0; end
    for (int j = 0; j < NUM_OUT; j++) begin m_out[j] = '0; m_pend[j] = 0; end
    m_rd  = '0;
    m_err = 0;
  endfunction

  function automatic logic [IW-1:0] mk(input logic [WIDTH-1:0] w, input bit good);
`ifdef IO_PARITY_EN
    logic p;
    p = ~^w;
    if (!good) p = ~p;
    return {p, w};
`else
    return w;
`endif
  endfunction

  function automatic void model_advance();
    int sel;
    logic [WIDTH-1:0] rd;
    logic [IW-1:0] w;
    sel = int'(bus.sel_read);
    rd  = '0;
    if (sel < NUM_IN) rd = m_word[sel];
    else if (sel == 30) begin for (int i = 0; i < NUM_IN; i++) rd[i] = m_fresh[i]; end
    else if (sel == 31) begin for (int j = 0; j < NUM_OUT; j++) rd[j] = m_pend[j]; end
`ifdef IO_PARITY_EN
    else if (sel == 29) rd = WIDTH'(m_err);
`endif
    m_rd = rd;
    for (int i = 0; i < NUM_IN; i++) begin
      bit consumed;
      consumed = (sel == i);
      if (bus.in_valid[i] && !m_fresh[i]) begin
        w = bus.in_data[i*IW +: IW];
`ifdef IO_PARITY_EN
        if ((^w) == 1'b1) begin m_word[i] = w[WIDTH-1:0]; m_fresh[i] = 1; end
        else begin
          m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
          if (consumed) m_fresh[i] = 0;
        end
`else
        m_word[i] = w[WIDTH-1:0];
        m_fresh[i] = 1;
`endif
      end else if (consumed) m_fresh[i] = 0;
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (bus.en_write && int'(bus.sel_write) == j) begin m_out[j] = bus.data_write; m_pend[j] = 1; end
      else if (bus.out_ready[j]) m_pend[j] = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_IN-1:0] rdy;
    logic [NUM_OUT-1:0] ov;
    logic [NUM_OUT*WIDTH-1:0] od;
    for (int i = 0; i < NUM_IN; i++) rdy[i] = ~m_fresh[i];
    for (int j = 0; j < NUM_OUT; j++) begin ov[j] = m_pend[j]; od[j*WIDTH +: WIDTH] = m_out[j]; end
    check({tag, ".data_read"}, 64'(bus.data_read), 64'(m_rd));
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'(rdy));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    check({tag, ".out_data"},  64'(bus.out_data),  64'(od));
  endtask

  task automatic tick();
    if (rst) model_reset(); else model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int ch, input logic [WIDTH-1:0] w, input bit good);
    bus.in_data[ch*IW +: IW] = mk(w, good);
    bus.in_valid[ch] = 1'b1;
  endtask

  task automatic cpu_write(input int sel, input logic [WIDTH-1:0] w);
    bus.en_write = 1'b1; bus.sel_write = 5'(sel); bus.data_write = w;
  endtask

  initial begin
    bus.sel_read = 5'd28; bus.sel_write = 5'd0; bus.en_write = 1'b0; bus.data_write = '0;
    bus.in_data = '0; bus.in_valid = '0; bus.out_ready = '0;
    model_reset();

    // Reset state
    tick(); tick();
    check("rst.data_read", 64'(bus.data_read), 64'h0);
    check("rst.in_ready",  64'(bus.in_ready),  64'h3f);
    check("rst.out_valid", 64'(bus.out_valid), 64'h0);
    check("rst.out_data",  64'(bus.out_data),  64'h0);
    rst = 1'b0;

    // Single input word, flag readback, read and consume, stalled second word
    offer(2, 15'h0037, 1); tick(); bus.in_valid = '0;
    check("in.ready_drop", 64'(bus.in_ready), 64'h3b); check_all("in.load");
    bus.sel_read = 5'd30; offer(2, 15'h0005, 1); tick();
    check("in.flags", 64'(bus.data_read), 64'h0004); check("in.stall", 64'(bus.in_ready), 64'h3b);
    bus.sel_read = 5'd2; tick();
    check("in.read_old", 64'(bus.data_read), 64'h0037); check("in.freed", 64'(bus.in_ready), 64'h3f);
    bus.sel_read = 5'd28; tick(); bus.in_valid = '0;
    check("in.accept2", 64'(bus.in_ready), 64'h3b); check_all("in.accept2");
    bus.sel_read = 5'd2; tick();
    check("in.read2", 64'(bus.data_read), 64'h0005);
    bus.sel_read = 5'd30; tick();
    check("in.flags_clear", 64'(bus.data_read), 64'h0000); check_all("in.end");
    bus.sel_read = 5'd20; tick(); check("rd.unmapped20", 64'(bus.data_read), 64'h0);
    bus.sel_read = 5'd29; tick();
`ifndef IO_PARITY_EN
    check("rd.sel29_zero", 64'(bus.data_read), 64'h0);
`endif

    // Pending output held while out_ready is low
    bus.sel_read = 5'd31; bus.out_ready = '0; cpu_write(1, 15'h0ABC); tick(); bus.en_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("out.pending", 64'(bus.out_valid), 64'h2);
      check("out.word", 64'(bus.out_data[1*WIDTH +: WIDTH]), 64'h0ABC);
      tick();
      check("out.flags", 64'(bus.data_read), 64'h0002);
    end
    bus.out_ready = 4'b0010;
    check("out.cycle4", 64'(bus.out_valid), 64'h2);
    tick(); check("out.done", 64'(bus.out_valid), 64'h0); check_all("out.done");
    bus.out_ready = '0;

    // Write coinciding with a completing handshake
    cpu_write(0, 15'h0456); tick();
    cpu_write(0, 15'h0123); bus.out_ready = 4'b0001; tick(); bus.en_write = 1'b0;
    check("wr_hs.valid", 64'(bus.out_valid), 64'h1);
    check("wr_hs.word", 64'(bus.out_data[0 +: WIDTH]), 64'h0123);
    tick(); check("wr_hs.drain", 64'(bus.out_valid), 64'h0); bus.out_ready = '0;
    cpu_write(5, 15'h7FFF); tick(); bus.en_write = 1'b0;
    check("wr.ignored", 64'(bus.out_valid), 64'h0); check_all("wr.ignored");

    // Every channel at once
    for (int i = 0; i < NUM_IN; i++) offer(i, WIDTH'($urandom), 1);
    tick(); bus.in_valid = '0;
    check("all.in", 64'(bus.in_ready), 64'h0); check_all("all.in");
    for (int j = 0; j < NUM_OUT; j++) begin cpu_write(j, WIDTH'($urandom)); tick(); end
    bus.en_write = 1'b0; bus.out_ready = '1; tick();
    check("all.out", 64'(bus.out_valid), 64'h0); check_all("all.out");
    bus.out_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin bus.sel_read = 5'(i); tick(); check_all("all.read"); end
    bus.sel_read = 5'd28;

`ifdef IO_PARITY_EN
    // Bad parity on channels 0 and 3 saturates the error counter
    offer(1, 15'h0011, 1); tick(); bus.in_valid = '0;
    for (int k = 0; k < 130; k++) begin
      offer(0, WIDTH'($urandom), 0); offer(3, WIDTH'($urandom), 0); tick();
    end
    bus.in_valid = '0;
    check("par.ready", 64'(bus.in_ready), 64'h3d);
    bus.sel_read = 5'd30; tick(); check("par.fresh", 64'(bus.data_read), 64'h0002);
    bus.sel_read = 5'd29; tick(); check("par.sat", 64'(bus.data_read), 64'd255);
    bus.sel_read = 5'd1; tick(); check("par.word", 64'(bus.data_read), 64'h0011);
    bus.sel_read = 5'd28; tick(); check_all("par.end");
`endif

    // Reset in the middle of handshakes
    cpu_write(3, 15'h1234); tick(); bus.en_write = 1'b0;
    for (int i = 0; i < NUM_IN; i++) offer(i, WIDTH'($urandom), 1);
    check("mid.pending", 64'(bus.out_valid), 64'h8);
    rst = 1'b1; #2;
    check("mid.data_read", 64'(bus.data_read), 64'h0);
    check("mid.out_valid", 64'(bus.out_valid), 64'h0);
    check("mid.out_data",  64'(bus.out_data),  64'h0);
    check("mid.in_ready",  64'(bus.in_ready),  64'h3f);
    tick(); check("mid.held", 64'(bus.in_ready), 64'h3f);
    bus.in_valid = '0; rst = 1'b0; tick();
    check("mid.no_latch", 64'(bus.in_ready), 64'h3f);
    bus.sel_read = 5'd0; tick(); check("mid.word0", 64'(bus.data_read), 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int s;
      for (int i = 0; i < NUM_IN; i++) begin
        bus.in_valid[i] = ($urandom_range(0, 2) == 0);
        bus.in_data[i*IW +: IW] = mk(WIDTH'($urandom), ($urandom_range(0, 7) != 0));
      end
      s = $urandom_range(0, NUM_IN + 4);
      bus.sel_read = (s < NUM_IN) ? 5'(s) : (s == NUM_IN) ? 5'd20 : 5'(28 + s - NUM_IN - 1);
      bus.en_write = ($urandom_range(0, 2) == 0);
      bus.sel_write = 5'($urandom_range(0, 7));
      bus.data_write = WIDTH'($urandom);
      bus.out_ready = NUM_OUT'($urandom);
      tick();
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
